// File: rtl/alu_control_mdu_if.sv
// Decode-to-EX bus of the ALU control unit: decode-side request inputs and
// EX/MDU-side registered outputs plus the combinational decode stall.
interface alu_control_mdu_if;
    logic       valid_i;
    logic       flush_i;
    logic [2:0] ALUOp;
    logic [5:0] ALUFunction;
    logic       stall_o;
    logic       valid_o;
    logic [3:0] ALUOperation;
    logic       JumpR_o;
    logic       hilo_sel_o;
    logic       mdu_start_o;
    logic       mdu_div_o;
    logic       mdu_busy_o;
    logic       mdu_done_o;

    modport master (
        output valid_i, flush_i, ALUOp, ALUFunction,
        input  stall_o, valid_o, ALUOperation, JumpR_o, hilo_sel_o,
               mdu_start_o, mdu_div_o, mdu_busy_o, mdu_done_o
    );

    modport slave (
        input  valid_i, flush_i, ALUOp, ALUFunction,
        output stall_o, valid_o, ALUOperation, JumpR_o, hilo_sel_o,
               mdu_start_o, mdu_div_o, mdu_busy_o, mdu_done_o
    );
endinterface

// File: rtl/alu_control_mdu.sv
// Registered MIPS ALU control: decodes ALUOp/funct into the EX operation code
// and sequences MULT/DIV with a latency down-counter that stalls HI/LO hazards.
module alu_control_mdu #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_control_mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_NOR  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_LUI  = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_SLT  = 4'b1010,
        OP_MULT = 4'b1011,
        OP_DIV  = 4'b1100,
        OP_HILO = 4'b1101,
        OP_JR   = 4'b1110,
        OP_NONE = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
        logic    jump_r;
        logic    hilo_sel;
        logic    mdu_start;
        logic    mdu_div;
    } ex_reg_t;

    localparam ex_reg_t BUBBLE = '{valid: 1'b0, op: OP_NONE, jump_r: 1'b0,
                                   hilo_sel: 1'b0, mdu_start: 1'b0, mdu_div: 1'b0};

    ex_reg_t          dec;
    ex_reg_t          ex_q;
    logic             dec_mult;
    logic             dec_div;
    logic             dec_hilo_class;
    logic             stall;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        dec_mult  = 1'b0;
        dec_div   = 1'b0;
        case (bus.ALUOp)
            3'b111: begin
                case (bus.ALUFunction)
                    6'b100100: dec.op = OP_AND;
                    6'b100101: dec.op = OP_OR;
                    6'b100111: dec.op = OP_NOR;
                    6'b100000: dec.op = OP_ADD;
                    6'b100010: dec.op = OP_SUB;
                    6'b000010: dec.op = OP_SRL;
                    6'b000000: dec.op = OP_SLL;
                    6'b101010: dec.op = OP_SLT;
                    6'b011000: begin dec.op = OP_MULT; dec_mult = 1'b1; end
                    6'b011010: begin dec.op = OP_DIV;  dec_div  = 1'b1; end
                    6'b010000: begin dec.op = OP_HILO; dec.hilo_sel = 1'b1; end
                    6'b010010: dec.op = OP_HILO;
                    6'b001000: begin dec.op = OP_JR; dec.jump_r = 1'b1; end
                    default:   dec.op = OP_NONE;
                endcase
            end
            3'b100:  dec.op = OP_ADD;   // ADDI
            3'b101:  dec.op = OP_OR;    // ORI
            3'b011:  dec.op = OP_LUI;
            3'b001:  dec.op = OP_BEQ;
            3'b010:  dec.op = OP_BNE;
            default: dec.op = OP_ADD;   // LW, SW
        endcase
        dec.mdu_start = dec_mult | dec_div;
        dec.mdu_div   = dec_div;
    end

    // HI/LO readers and writers must wait until the in-flight MDU op retires.
    assign dec_hilo_class = dec_mult | dec_div | (dec.op == OP_HILO);
    assign stall          = bus.valid_i & dec_hilo_class & (cnt != '0);
    assign accept         = bus.valid_i & ~stall & ~bus.flush_i;

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= BUBBLE;
        end else if (accept) begin
            ex_q <= dec;
        end else begin
            ex_q <= BUBBLE;
        end
    end

    // Flush only squashes the EX register; an issued MULT/DIV runs to completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept && dec_mult) begin
            cnt <= CNT_W'(MULT_CYCLES);
        end else if (accept && dec_div) begin
            cnt <= CNT_W'(DIV_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.stall_o      = stall;
    assign bus.valid_o      = ex_q.valid;
    assign bus.ALUOperation = ex_q.op;
    assign bus.JumpR_o      = ex_q.jump_r;
    assign bus.hilo_sel_o   = ex_q.hilo_sel;
    assign bus.mdu_start_o  = ex_q.mdu_start;
    assign bus.mdu_div_o    = ex_q.mdu_div;
    assign bus.mdu_busy_o   = (cnt != '0);
    assign bus.mdu_done_o   = (cnt == CNT_W'(1));
endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a cycle-count model.
module tb_alu_control_mdu;
  localparam int MULT_CYCLES = 4;
  localparam int DIV_CYCLES  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  alu_control_mdu_if bus();

  alu_control_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode tables.
  typedef struct packed {
    logic [3:0] op;
    logic       jr;
    logic       hilo;
    logic       mult;
    logic       div;
  } ref_t;

  function automatic ref_t ref_decode(input logic [2:0] aluop, input logic [5:0] fn);
    logic [3:0] itype [8];
    ref_t r;
    itype = '{4'h3, 4'h8, 4'h9, 4'h7, 4'h3, 4'h1, 4'h3, 4'hF};
    r = '{op: 4'hF, default: '0};
    if (aluop != 3'b111) begin
      r.op = itype[aluop];
    end else begin
      case (fn)
        6'h24: r.op = 4'h0;
        6'h25: r.op = 4'h1;
        6'h27: r.op = 4'h2;
        6'h20: r.op = 4'h3;
        6'h22: r.op = 4'h4;
        6'h02: r.op = 4'h5;
        6'h00: r.op = 4'h6;
        6'h2A: r.op = 4'hA;
        6'h18: begin r.op = 4'hB; r.mult = 1'b1; end
        6'h1A: begin r.op = 4'hC; r.div = 1'b1; end
        6'h10: begin r.op = 4'hD; r.hilo = 1'b1; end
        6'h12: r.op = 4'hD;
        6'h08: begin r.op = 4'hE; r.jr = 1'b1; end
        default: r.op = 4'hF;
      endcase
    end
    return r;
  endfunction

  // Model: busy is "current cycle index <= last busy cycle index".
  int         cyc = 0;
  int         busy_until = -1;
  logic       m_valid = 1'b0, m_jr = 1'b0, m_hilo = 1'b0, m_start = 1'b0, m_div = 1'b0;
  logic [3:0] m_op = 4'hF;
  ref_t       m_dec;
  logic       m_busy, m_done, m_stall, m_acc;

  assign m_dec   = ref_decode(bus.ALUOp, bus.ALUFunction);
  assign m_busy  = (cyc <= busy_until);
  assign m_done  = (cyc == busy_until);
  assign m_stall = bus.valid_i && (m_dec.mult || m_dec.div || m_dec.op == 4'hD) && m_busy;
  assign m_acc   = bus.valid_i && !m_stall && !bus.flush_i;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_until <= cyc - 1;
      m_valid <= 1'b0; m_op <= 4'hF; m_jr <= 1'b0;
      m_hilo  <= 1'b0; m_start <= 1'b0; m_div <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_acc) begin
        m_valid <= 1'b1; m_op <= m_dec.op; m_jr <= m_dec.jr; m_hilo <= m_dec.hilo;
        m_start <= m_dec.mult || m_dec.div; m_div <= m_dec.div;
        if (m_dec.mult) busy_until <= cyc + MULT_CYCLES;
        if (m_dec.div)  busy_until <= cyc + DIV_CYCLES;
      end else begin
        m_valid <= 1'b0; m_op <= 4'hF; m_jr <= 1'b0;
        m_hilo  <= 1'b0; m_start <= 1'b0; m_div <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_o",      bus.stall_o,      m_stall);
      check("valid_o",      bus.valid_o,      m_valid);
      check("ALUOperation", bus.ALUOperation, m_op);
      check("JumpR_o",      bus.JumpR_o,      m_jr);
      check("hilo_sel_o",   bus.hilo_sel_o,   m_hilo);
      check("mdu_start_o",  bus.mdu_start_o,  m_start);
      check("mdu_div_o",    bus.mdu_div_o,    m_div);
      check("mdu_busy_o",   bus.mdu_busy_o,   m_busy);
      check("mdu_done_o",   bus.mdu_done_o,   m_done);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [2:0] op, input logic [5:0] fn);
    bus.valid_i = v; bus.flush_i = f; bus.ALUOp = op; bus.ALUFunction = fn;
    #1;
  endtask

  task automatic wait_idle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    for (int i = 0; i < 100 && bus.mdu_busy_o; i++) cycle();
    check("idle_timeout", bus.mdu_busy_o, 1'b0);
  endtask

  typedef struct {
    logic [2:0] aluop;
    logic [5:0] fn;
    logic [3:0] code;
    logic       jr;
    logic       hilo;
  } vec_t;

  vec_t vecs [21];
  int   stalls, starts, done_at, bc;

  initial begin
    vecs = '{
      '{3'b111, 6'b100100, 4'b0000, 1'b0, 1'b0}, '{3'b111, 6'b100101, 4'b0001, 1'b0, 1'b0},
      '{3'b111, 6'b100111, 4'b0010, 1'b0, 1'b0}, '{3'b111, 6'b100000, 4'b0011, 1'b0, 1'b0},
      '{3'b111, 6'b100010, 4'b0100, 1'b0, 1'b0}, '{3'b111, 6'b000010, 4'b0101, 1'b0, 1'b0},
      '{3'b111, 6'b000000, 4'b0110, 1'b0, 1'b0}, '{3'b111, 6'b101010, 4'b1010, 1'b0, 1'b0},
      '{3'b111, 6'b010000, 4'b1101, 1'b0, 1'b1}, '{3'b111, 6'b010010, 4'b1101, 1'b0, 1'b0},
      '{3'b111, 6'b001000, 4'b1110, 1'b1, 1'b0}, '{3'b111, 6'b111111, 4'b1111, 1'b0, 1'b0},
      '{3'b111, 6'b011000, 4'b1011, 1'b0, 1'b0}, '{3'b100, 6'b111111, 4'b0011, 1'b0, 1'b0},
      '{3'b101, 6'b000000, 4'b0001, 1'b0, 1'b0}, '{3'b011, 6'b101010, 4'b0111, 1'b0, 1'b0},
      '{3'b001, 6'b001000, 4'b1000, 1'b0, 1'b0}, '{3'b010, 6'b011000, 4'b1001, 1'b0, 1'b0},
      '{3'b110, 6'b010000, 4'b0011, 1'b0, 1'b0}, '{3'b000, 6'b011010, 4'b0011, 1'b0, 1'b0},
      '{3'b111, 6'b011010, 4'b1100, 1'b0, 1'b0}
    };
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ALUOp = 3'b000; bus.ALUFunction = 6'h00;

    // Reset state
    cycle();
    chk_en = 1'b1;
    cycle();
    check("rst_valid_o", bus.valid_o, 1'b0);
    check("rst_op",      bus.ALUOperation, 4'hF);
    check("rst_busy",    bus.mdu_busy_o, 1'b0);
    check("rst_stall",   bus.stall_o, 1'b0);
    reset = 1'b0;

    // Decode sweep with literal codes
    foreach (vecs[i]) begin
      drive(1'b1, 1'b0, vecs[i].aluop, vecs[i].fn);
      check($sformatf("sweep%0d_stall", i), bus.stall_o, 1'b0);
      cycle();
      check($sformatf("sweep%0d_valid", i), bus.valid_o, 1'b1);
      check($sformatf("sweep%0d_code", i),  bus.ALUOperation, vecs[i].code);
      check($sformatf("sweep%0d_jr", i),    bus.JumpR_o, vecs[i].jr);
      check($sformatf("sweep%0d_hilo", i),  bus.hilo_sel_o, vecs[i].hilo);
    end
    wait_idle();

    // MULT followed immediately by MFLO
    drive(1'b1, 1'b0, 3'b111, 6'b011000);
    cycle();
    drive(1'b1, 1'b0, 3'b111, 6'b010010);
    stalls = 0; starts = 0; done_at = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.stall_o) break;
      stalls++;
      if (bus.mdu_start_o) starts++;
      if (bus.mdu_done_o) done_at = stalls;
      cycle();
    end
    check("mult_stall_cycles", stalls, 4);
    check("mult_start_pulses", starts, 1);
    check("mult_done_at",      done_at, 4);
    cycle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    check("mflo_valid", bus.valid_o, 1'b1);
    check("mflo_code",  bus.ALUOperation, 4'b1101);
    check("mflo_hilo",  bus.hilo_sel_o, 1'b0);
    wait_idle();

    // DIV then ADD and SUB while busy
    drive(1'b1, 1'b0, 3'b111, 6'b011010);
    cycle();
    bc = bus.mdu_busy_o ? 1 : 0;
    drive(1'b1, 1'b0, 3'b111, 6'b100000);
    check("div_add_stall", bus.stall_o, 1'b0);
    cycle();
    if (bus.mdu_busy_o) bc++;
    check("div_add_code", bus.ALUOperation, 4'b0011);
    drive(1'b1, 1'b0, 3'b111, 6'b100010);
    check("div_sub_stall", bus.stall_o, 1'b0);
    cycle();
    if (bus.mdu_busy_o) bc++;
    check("div_sub_code", bus.ALUOperation, 4'b0100);
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    for (int i = 0; i < 64 && bus.mdu_busy_o; i++) begin
      cycle();
      if (bus.mdu_busy_o) bc++;
    end
    check("div_busy_cycles", bc, 32);

    // Flush with a valid MULT while idle
    wait_idle();
    drive(1'b1, 1'b1, 3'b111, 6'b011000);
    cycle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    check("flush_valid", bus.valid_o, 1'b0);
    check("flush_code",  bus.ALUOperation, 4'hF);
    check("flush_start", bus.mdu_start_o, 1'b0);
    check("flush_busy",  bus.mdu_busy_o, 1'b0);

    // Flush held during a busy DIV
    drive(1'b1, 1'b0, 3'b111, 6'b011010);
    cycle();
    drive(1'b1, 1'b1, 3'b111, 6'b100000);
    bc = 0; done_at = 0;
    for (int i = 0; i < 64; i++) begin
      if (!bus.mdu_busy_o) break;
      bc++;
      if (bus.mdu_done_o) done_at = bc;
      cycle();
    end
    check("flushdiv_busy_cycles", bc, 32);
    check("flushdiv_done_at",     done_at, 32);
    wait_idle();

    // Asynchronous reset in the 10th busy cycle of a DIV
    drive(1'b1, 1'b0, 3'b111, 6'b011010);
    cycle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    repeat (8) cycle();
    drive(1'b1, 1'b0, 3'b111, 6'b100000);
    cycle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    check("pre_rst_busy",  bus.mdu_busy_o, 1'b1);
    check("pre_rst_valid", bus.valid_o, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", bus.valid_o, 1'b0);
    check("async_rst_code",  bus.ALUOperation, 4'hF);
    check("async_rst_busy",  bus.mdu_busy_o, 1'b0);
    check("async_rst_done",  bus.mdu_done_o, 1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'b111, 6'b010000);
    check("mfhi_after_rst_stall", bus.stall_o, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 3'b000, 6'h00);
    check("mfhi_after_rst_code", bus.ALUOperation, 4'b1101);
    check("mfhi_after_rst_hilo", bus.hilo_sel_o, 1'b1);

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] fn_list [14];
      logic [2:0] op;
      logic [5:0] fn;
      fn_list = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h02, 6'h00,
                  6'h2A, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h08, 6'h3F};
      op = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) != 0) ? fn_list[$urandom_range(0, 13)] : 6'($urandom_range(0, 63));
      cycle();
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), op, fn);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
    end

    cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
